shared_ram_arbiter: RTL

- Owns the 2048 x 32 dual-port log/transfer RAM and shares it between four requesters:
  - UART-rx logger write strobes
  - JTAG write strobes and JTAG read address
  - UART-tx block reader
  - neorv32 Wishbone slave port
- The RAM has one write port and one read port. Each port has its own fixed-priority arbiter.
- Single-cycle strobe requesters get one-deep pending slots, so a collision delays them instead of dropping them.
- Sits in the top level between jtag_top, the UART logic and the CPU bus.

---
 rtl/shared_ram_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/shared_ram_arbiter.sv
// Shares one 2048x32 RAM between the rx logger, JTAG, tx reader and a Wishbone slave port.
// Write port priority is rx > jt > wb; read port priority is tx > wb > jt, with a starvation override for jt.
module shared_ram_arbiter #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rx_we_i,
    input  logic [ADDR_W-1:0] rx_addr_i,
    input  logic [DATA_W-1:0] rx_data_i,
    input  logic              jt_we_i,
    input  logic [ADDR_W-1:0] jt_waddr_i,
    input  logic [DATA_W-1:0] jt_wdata_i,
    input  logic [ADDR_W-1:0] jt_raddr_i,
    output logic [DATA_W-1:0] jt_rdata_o,
    input  logic              tx_req_i,
    input  logic [ADDR_W-1:0] tx_addr_i,
    output logic              tx_ack_o,
    output logic [DATA_W-1:0] tx_data_o,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [ADDR_W+1:0] wb_adr_i,
    input  logic [3:0]        wb_sel_i,
    input  logic [DATA_W-1:0] wb_dat_i,
    output logic [DATA_W-1:0] wb_dat_o,
    output logic              wb_ack_o,
    input  logic              ovf_clr_i,
    output logic [1:0]        ovf_o
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {TAG_NONE, TAG_TX, TAG_WB, TAG_JT} tag_e;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    tag_e              rd_tag_q, rd_tag_d;
    logic              rx_vld_q, rx_vld_d, jt_vld_q, jt_vld_d;
    logic [ADDR_W-1:0] rx_addr_q, rx_addr_d, jt_addr_q, jt_addr_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d, jt_data_q, jt_data_d;
    logic [1:0]        ovf_q, ovf_d;
    logic              wb_ack_q, wb_ack_d;
    logic [7:0]        starve_cnt_q, starve_cnt_d;
    logic [DATA_W-1:0] tx_hold_q, tx_hold_d, wb_hold_q, wb_hold_d, jt_hold_q, jt_hold_d;

    logic              wb_req, wb_wr_req, wb_rd_req, starve;
    logic              rx_wr_gnt, jt_wr_gnt, wb_wr_gnt;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic [DATA_W-1:0] wr_data;
    logic [3:0]        wr_be;

    always_comb begin
        // The ack cycle itself blocks a re-grant of the still-asserted request.
        wb_req    = wb_cyc_i && wb_stb_i && !wb_ack_q;
        wb_wr_req = wb_req && wb_we_i;
        wb_rd_req = wb_req && !wb_we_i;

        rx_wr_gnt = rx_vld_q;
        jt_wr_gnt = jt_vld_q && !rx_vld_q;
        wb_wr_gnt = wb_wr_req && !rx_vld_q && !jt_vld_q;

        wr_en   = rx_wr_gnt || jt_wr_gnt || wb_wr_gnt;
        wr_addr = wb_adr_i[ADDR_W+1:2];
        wr_data = wb_dat_i;
        wr_be   = wb_sel_i;
        if (rx_wr_gnt) begin
            wr_addr = rx_addr_q;
            wr_data = rx_data_q;
            wr_be   = 4'hF;
        end else if (jt_wr_gnt) begin
            wr_addr = jt_addr_q;
            wr_data = jt_data_q;
            wr_be   = 4'hF;
        end

        // 255 losing cycles already counted, so this slot is the 256th.
        starve = (starve_cnt_q == 8'hFF);
        if (starve) begin
            rd_tag_d = TAG_JT;
        end else if (tx_req_i && rd_tag_q != TAG_TX) begin
            rd_tag_d = TAG_TX;
        end else if (wb_rd_req) begin
            rd_tag_d = TAG_WB;
        end else begin
            rd_tag_d = TAG_JT;
        end

        case (rd_tag_d)
            TAG_TX:  rd_addr = tx_addr_i;
            TAG_WB:  rd_addr = wb_adr_i[ADDR_W+1:2];
            default: rd_addr = jt_raddr_i;
        endcase
        starve_cnt_d = (rd_tag_d == TAG_JT) ? 8'd0 : starve_cnt_q + 8'd1;

        rx_vld_d  = rx_vld_q && !rx_wr_gnt;
        rx_addr_d = rx_addr_q;
        rx_data_d = rx_data_q;
        jt_vld_d  = jt_vld_q && !jt_wr_gnt;
        jt_addr_d = jt_addr_q;
        jt_data_d = jt_data_q;
        ovf_d     = ovf_clr_i ? 2'b00 : ovf_q;
        if (rx_we_i) begin
            rx_vld_d  = 1'b1;
            rx_addr_d = rx_addr_i;
            rx_data_d = rx_data_i;
            if (rx_vld_q && !rx_wr_gnt) ovf_d[0] = 1'b1;
        end
        if (jt_we_i) begin
            jt_vld_d  = 1'b1;
            jt_addr_d = jt_waddr_i;
            jt_data_d = jt_wdata_i;
            if (jt_vld_q && !jt_wr_gnt) ovf_d[1] = 1'b1;
        end

        wb_ack_d  = wb_wr_gnt || (rd_tag_d == TAG_WB);
        tx_hold_d = (rd_tag_q == TAG_TX) ? rd_data_q : tx_hold_q;
        wb_hold_d = (rd_tag_q == TAG_WB) ? rd_data_q : wb_hold_q;
        jt_hold_d = (rd_tag_q == TAG_JT) ? rd_data_q : jt_hold_q;
    end

    // Read samples the pre-write contents, so a same-address collision returns old data.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en && wr_be[i]) mem[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
        end
        rd_data_q <= mem[rd_addr];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_tag_q     <= TAG_NONE;
            rx_vld_q     <= 1'b0;
            rx_addr_q    <= '0;
            rx_data_q    <= '0;
            jt_vld_q     <= 1'b0;
            jt_addr_q    <= '0;
            jt_data_q    <= '0;
            ovf_q        <= 2'b00;
            wb_ack_q     <= 1'b0;
            starve_cnt_q <= 8'd0;
            tx_hold_q    <= '0;
            wb_hold_q    <= '0;
            jt_hold_q    <= '0;
        end else begin
            rd_tag_q     <= rd_tag_d;
            rx_vld_q     <= rx_vld_d;
            rx_addr_q    <= rx_addr_d;
            rx_data_q    <= rx_data_d;
            jt_vld_q     <= jt_vld_d;
            jt_addr_q    <= jt_addr_d;
            jt_data_q    <= jt_data_d;
            ovf_q        <= ovf_d;
            wb_ack_q     <= wb_ack_d;
            starve_cnt_q <= starve_cnt_d;
            tx_hold_q    <= tx_hold_d;
            wb_hold_q    <= wb_hold_d;
            jt_hold_q    <= jt_hold_d;
        end
    end

    assign tx_ack_o   = (rd_tag_q == TAG_TX);
    assign tx_data_o  = (rd_tag_q == TAG_TX) ? rd_data_q : tx_hold_q;
    assign wb_dat_o   = (rd_tag_q == TAG_WB) ? rd_data_q : wb_hold_q;
    assign jt_rdata_o = (rd_tag_q == TAG_JT) ? rd_data_q : jt_hold_q;
    // A master that drops cyc loses its pending ack.
    assign wb_ack_o   = wb_ack_q && wb_cyc_i;
    assign ovf_o      = ovf_q;

endmodule
